hazard_ctrl: RTL

Pipeline hazard and stall controller for the 5-stage MIPS core. Generates the `keep`, bubble and flush controls consumed by the PC register, IF/ID register and the ID/EX register's `keep_d` input and control-field zeroing mux. Resolves load-use hazards, taken-branch flushes, data-memory wait freezes and the occupancy of the multi-cycle multiply/divide unit. Sits beside the ID stage, observing ID and EX.

---
 rtl/hazard_ctrl_pkg.sv | 23 ++
 rtl/md_busy_counter.sv | 34 +++
 rtl/hazard_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/stall controller.
// Holds the mult/div FSM state encoding and the bundled hazard control word.
// Pure declarations: no logic, no latency, no flow control.
package hazard_ctrl_pkg;

    localparam int PIPE_R_WIDTH = 5;

    typedef enum logic {
        IDLE    = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    typedef struct packed {
        logic pc_keep;
        logic if_id_keep;
        logic id_ex_keep;
        logic ex_mem_keep;
        logic id_ex_bubble;
        logic if_id_flush;
        logic md_start;
    } hz_ctrl_t;

endpackage

// File: rtl/md_busy_counter.sv
// Mult/div occupancy counter: loads MD_CYCLES-1, counts down to zero and holds.
// Load/decrement take effect on the negedge; zero flag is combinational from the count.
// No backpressure: the count advances on every enabled edge, pipeline freezes included.
module md_busy_counter
    import hazard_ctrl_pkg::*;
#(
    parameter int MD_CYCLES = 32,
    localparam int CW = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    localparam logic [CW-1:0] LOAD_VAL = CW'(MD_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    // Saturating at zero keeps the counter from wrapping if dec is held.
    always_ff @(negedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= LOAD_VAL;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage core: load-use, branch flush, memory freeze, mult/div occupancy.
// Control outputs are combinational from state and inputs (zero latency); FSM state updates on negedge.
// mem_wait freezes every stage; mult/div state keeps advancing underneath the freeze.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int R_WIDTH   = PIPE_R_WIDTH,
    parameter int MD_CYCLES = 32
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [R_WIDTH-1:0] id_rs_i,
    input  logic [R_WIDTH-1:0] id_rt_i,
    input  logic               id_uses_rs_i,
    input  logic               id_uses_rt_i,
    input  logic               id_md_start_i,
    input  logic               id_md_read_i,
    input  logic               ex_mem_read_i,
    input  logic [R_WIDTH-1:0] ex_rt_i,
    input  logic               ex_branch_taken_i,
    input  logic               mem_wait_i,
    output logic               pc_keep_o,
    output logic               if_id_keep_o,
    output logic               id_ex_keep_o,
    output logic               ex_mem_keep_o,
    output logic               id_ex_bubble_o,
    output logic               if_id_flush_o,
    output logic               md_start_o,
    output logic               md_busy_o,
    output logic               md_done_o
);

    md_state_e state_q;
    md_state_e state_d;
    hz_ctrl_t  ctrl;
    logic      cnt_zero;
    logic      load_use;
    logic      md_stall;

    // $zero is never a real load destination, so it cannot create a hazard.
    assign load_use = ex_mem_read_i && (ex_rt_i != '0) &&
                      ((id_uses_rs_i && (id_rs_i == ex_rt_i)) ||
                       (id_uses_rt_i && (id_rt_i == ex_rt_i)));

    assign md_stall = (state_q == MD_BUSY) && (id_md_start_i || id_md_read_i);

    always_comb begin
        ctrl = '0;
        if (mem_wait_i) begin
            ctrl.pc_keep     = 1'b1;
            ctrl.if_id_keep  = 1'b1;
            ctrl.id_ex_keep  = 1'b1;
            ctrl.ex_mem_keep = 1'b1;
        end else if (ex_branch_taken_i) begin
            ctrl.if_id_flush  = 1'b1;
            ctrl.id_ex_bubble = 1'b1;
        end else if (load_use || md_stall) begin
            ctrl.pc_keep      = 1'b1;
            ctrl.if_id_keep   = 1'b1;
            ctrl.id_ex_bubble = 1'b1;
        end else if ((state_q == IDLE) && id_md_start_i) begin
            ctrl.md_start = 1'b1;
        end
    end

    // The op in flight is always older than anything in EX, so only reset aborts it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ctrl.md_start) state_d = MD_BUSY;
            MD_BUSY: if (cnt_zero)      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(negedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    md_busy_counter #(
        .MD_CYCLES (MD_CYCLES)
    ) u_md_busy_counter (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .load_i  (ctrl.md_start),
        .dec_i   (state_q == MD_BUSY),
        .zero_o  (cnt_zero)
    );

    assign pc_keep_o      = ctrl.pc_keep;
    assign if_id_keep_o   = ctrl.if_id_keep;
    assign id_ex_keep_o   = ctrl.id_ex_keep;
    assign ex_mem_keep_o  = ctrl.ex_mem_keep;
    assign id_ex_bubble_o = ctrl.id_ex_bubble;
    assign if_id_flush_o  = ctrl.if_id_flush;
    assign md_start_o     = ctrl.md_start;
    assign md_busy_o      = (state_q == MD_BUSY);
    assign md_done_o      = (state_q == MD_BUSY) && cnt_zero;

endmodule
